// File: rtl/alu_pkg.sv
// Shared ALUControl encodings, FSM state encodings and shift classification for the ALU
// execute stage. Used by alu_decoder, alu_comb_core and alu_exec_unit.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRAI = 4'b1001;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BGEU = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    typedef enum logic [1:0] {
        ShNone,
        ShLeft,
        ShRightLog,
        ShRightArith
    } shift_kind_e;

    function automatic shift_kind_e shift_kind(input logic [3:0] ctrl);
        shift_kind_e kind;
        kind = ShNone;
        case (ctrl)
            ALU_SLL:           kind = ShLeft;
            ALU_SRL:           kind = ShRightLog;
            ALU_SRA, ALU_SRAI: kind = ShRightArith;
            default:           kind = ShNone;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle non-shift ALU datapath: add/sub, logic ops, compares and the illegal-code decode.
// Shift codes yield zero here; the execute unit produces shift results itself.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    logic signed_lt;
    logic unsigned_lt;

    assign signed_lt   = $signed(src_a) < $signed(src_b);
    assign unsigned_lt = src_a < src_b;

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (alu_ctrl)
            ALU_ADD:  result = src_a + src_b;
            ALU_SUB:  result = src_a - src_b;
            ALU_AND:  result = src_a & src_b;
            ALU_OR:   result = src_a | src_b;
            ALU_XOR:  result = src_a ^ src_b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, signed_lt};
            ALU_BGE:  result = {{(WIDTH-1){1'b0}}, ~signed_lt};
            ALU_BGEU: result = {{(WIDTH-1){1'b0}}, ~unsigned_lt};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, unsigned_lt};
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SRAI: result = '0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready on both sides. Shifts run one bit per cycle unless
// ALU_FAST_SHIFT_EN is defined, which swaps in a single-cycle barrel shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH-1:0]   core_result;
    logic               core_illegal;
    logic [SHAMT_W-1:0] shamt;
    shift_kind_e        kind_in;

    assign shamt   = src_b[SHAMT_W-1:0];
    assign kind_in = shift_kind(alu_ctrl);

    alu_comb_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .alu_ctrl (alu_ctrl),
        .src_a    (src_a),
        .src_b    (src_b),
        .result   (core_result),
        .illegal  (core_illegal)
    );

`ifdef ALU_FAST_SHIFT_EN
    logic [WIDTH-1:0] barrel;

    always_comb begin
        barrel = src_a;
        case (kind_in)
            ShLeft:       barrel = src_a << shamt;
            ShRightLog:   barrel = src_a >> shamt;
            ShRightArith: barrel = WIDTH'($signed(src_a) >>> shamt);
            default:      barrel = src_a;
        endcase
    end
`else
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    shift_kind_e        kind_q, kind_d;
    logic [WIDTH-1:0]   step;

    // One-bit shift of the working register; sra replicates the sign bit.
    always_comb begin
        step = work_q;
        case (kind_q)
            ShLeft:       step = {work_q[WIDTH-2:0], 1'b0};
            ShRightLog:   step = {1'b0, work_q[WIDTH-1:1]};
            ShRightArith: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default:      step = work_q;
        endcase
    end
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
        work_d    = work_q;
        cnt_d     = cnt_q;
        kind_d    = kind_q;
`endif
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d   = StDone;
                    illegal_d = 1'b0;
                    if (kind_in == ShNone) begin
                        result_d  = core_result;
                        illegal_d = core_illegal;
                    end
`ifdef ALU_FAST_SHIFT_EN
                    else begin
                        result_d = barrel;
                    end
`else
                    else if (shamt == '0) begin
                        result_d = src_a;
                    end else begin
                        work_d  = src_a;
                        cnt_d   = shamt;
                        kind_d  = kind_in;
                        state_d = StShift;
                    end
`endif
                    if (state_d == StDone) begin
                        zero_d = (result_d == '0);
                    end
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            StShift: begin
                work_d = step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    result_d  = step;
                    zero_d    = (step == '0);
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
            end
`endif
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            work_q    <= '0;
            cnt_q     <= '0;
            kind_q    <= ShNone;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
